mmio_uart_tx: RTL and testbench



---
 rtl/mmio_uart_tx_pkg.sv | 28 ++
 rtl/mmio_uart_tx_if.sv | 27 ++
 rtl/mmio_uart_tx_fifo.sv | 60 ++++++
 rtl/mmio_uart_tx.sv | 172 +++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mmio_uart_tx_pkg.sv
// Shared types and constants for the memory-mapped UART transmitter.
// Status word layout and register offsets live here so software-facing bits are defined once.
package mmio_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  localparam int unsigned ST_BUSY    = 0;
  localparam int unsigned ST_FULL    = 1;
  localparam int unsigned ST_EMPTY   = 2;
  localparam int unsigned ST_OVF     = 3;
  localparam int unsigned ST_CNT_LSB = 4;

  localparam logic [31:0] STATUS_OFFSET = 32'd4;

  // FIFO occupancy is reported in a 4-bit field; deeper FIFOs read as 15.
  function automatic logic [3:0] satNibble(input logic [31:0] cnt);
    if (cnt > 32'd15) begin
      return 4'hF;
    end
    return cnt[3:0];
  endfunction

endpackage

// File: rtl/mmio_uart_tx_if.sv
// CPU data-store bus as seen by a memory-mapped peripheral.
// The CPU side drives address/data/strobe; the peripheral returns hit and read data.
interface mmio_uart_tx_if;

  logic [31:0] memAddress;
  logic [31:0] memWriteData;
  logic        memWriteEnable;
  logic        hit;
  logic [31:0] rdData;

  modport master (
    output memAddress,
    output memWriteData,
    output memWriteEnable,
    input  hit,
    input  rdData
  );

  modport slave (
    input  memAddress,
    input  memWriteData,
    input  memWriteEnable,
    output hit,
    output rdData
  );

endinterface

// File: rtl/mmio_uart_tx_fifo.sv
// Synchronous FIFO with occupancy count; a push into a full FIFO is accepted only when
// a pop happens in the same cycle. Pops from an empty FIFO are ignored (no bypass).
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned CntW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CntW-1:0]  count
);

  localparam int unsigned AddrW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AddrW-1:0] wrPtrQ, rdPtrQ;
  logic [CntW-1:0]  countQ;
  logic             doPush, doPop;

  assign full   = (countQ == CntW'(DEPTH));
  assign empty  = (countQ == '0);
  assign doPop  = pop & ~empty;
  assign doPush = push & (~full | doPop);
  assign dout   = mem[rdPtrQ];
  assign count  = countQ;

  // Pointers are power-of-two wide, so natural overflow is the modulo wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrPtrQ <= '0;
      rdPtrQ <= '0;
      countQ <= '0;
    end else begin
      if (doPush) begin
        wrPtrQ <= wrPtrQ + 1'b1;
      end
      if (doPop) begin
        rdPtrQ <= rdPtrQ + 1'b1;
      end
      unique case ({doPush, doPop})
        2'b10:   countQ <= countQ + 1'b1;
        2'b01:   countQ <= countQ - 1'b1;
        default: countQ <= countQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) begin
      mem[wrPtrQ] <= din;
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: stores to DATA queue a byte, STATUS reads/clears state.
// Frames go out LSB first; the FSM chains frames back to back while the FIFO has data.
module mmio_uart_tx
  import mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_8000,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic          clk,
  input  logic          reset,
  mmio_uart_tx_if.slave bus,
  output logic          tx,
  output logic          busy
);

  localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);
  localparam int unsigned CntW  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);
  localparam logic [31:0] StatusAddr = BASE_ADDR + STATUS_OFFSET;

  tx_state_t        stateQ, stateD;
  logic [BaudW-1:0] baudQ, baudD;
  logic [2:0]       bitQ, bitD;
  logic [7:0]       shiftQ, shiftD;
  logic             txQ, txD;
  logic             ovfQ, ovfD;

  logic            hitData, hitStatus;
  logic            pushReq, pop, ovfClear;
  logic [7:0]      fifoDout;
  logic            fifoFull, fifoEmpty;
  logic [CntW-1:0] fifoCount;
  logic [31:0]     statusWord;
  logic            baudEnd;
  logic            unusedWriteData;

  assign hitData   = (bus.memAddress == BASE_ADDR);
  assign hitStatus = (bus.memAddress == StatusAddr);
  assign bus.hit   = hitData | hitStatus;
  assign pushReq   = bus.memWriteEnable & hitData;
  assign ovfClear  = bus.memWriteEnable & hitStatus & bus.memWriteData[ST_OVF];

  assign unusedWriteData = ^bus.memWriteData[31:8];

  sync_fifo #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH)
  ) uFifo (
    .clk  (clk),
    .reset(reset),
    .push (pushReq),
    .din  (bus.memWriteData[7:0]),
    .pop  (pop),
    .dout (fifoDout),
    .full (fifoFull),
    .empty(fifoEmpty),
    .count(fifoCount)
  );

  always_comb begin
    statusWord                       = '0;
    statusWord[ST_BUSY]              = (stateQ != IDLE);
    statusWord[ST_FULL]              = fifoFull;
    statusWord[ST_EMPTY]             = fifoEmpty;
    statusWord[ST_OVF]               = ovfQ;
    statusWord[ST_CNT_LSB +: 4]      = satNibble(32'(fifoCount));
  end

  assign bus.rdData = hitStatus ? statusWord : 32'h0;
  assign busy       = (stateQ != IDLE) | ~fifoEmpty;
  assign tx         = txQ;

  // A full FIFO still accepts the push when the FSM pops in the same cycle.
  always_comb begin
    ovfD = ovfQ;
    if (pushReq && fifoFull && !pop) begin
      ovfD = 1'b1;
    end
    if (ovfClear) begin
      ovfD = 1'b0;
    end
  end

  assign baudEnd = (baudQ == BaudLast);

  always_comb begin
    stateD = stateQ;
    baudD  = baudQ;
    bitD   = bitQ;
    shiftD = shiftQ;
    txD    = txQ;
    pop    = 1'b0;
    unique case (stateQ)
      IDLE: begin
        txD = 1'b1;
        if (!fifoEmpty) begin
          pop    = 1'b1;
          shiftD = fifoDout;
          stateD = START;
          baudD  = '0;
          txD    = 1'b0;
        end
      end
      START: begin
        if (baudEnd) begin
          stateD = DATA;
          baudD  = '0;
          bitD   = '0;
          txD    = shiftQ[0];
        end else begin
          baudD = baudQ + 1'b1;
        end
      end
      DATA: begin
        if (baudEnd) begin
          baudD  = '0;
          shiftD = shiftQ >> 1;
          if (bitQ == 3'd7) begin
            stateD = STOP;
            txD    = 1'b1;
          end else begin
            bitD = bitQ + 1'b1;
            txD  = shiftQ[1];
          end
        end else begin
          baudD = baudQ + 1'b1;
        end
      end
      STOP: begin
        if (baudEnd) begin
          baudD = '0;
          // Chain straight into the next start bit so frames have no idle gap.
          if (!fifoEmpty) begin
            pop    = 1'b1;
            shiftD = fifoDout;
            stateD = START;
            txD    = 1'b0;
          end else begin
            stateD = IDLE;
            txD    = 1'b1;
          end
        end else begin
          baudD = baudQ + 1'b1;
        end
      end
      default: begin
        stateD = IDLE;
        txD    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateQ <= IDLE;
      baudQ  <= '0;
      bitQ   <= '0;
      shiftQ <= '0;
      txQ    <= 1'b1;
      ovfQ   <= 1'b0;
    end else begin
      stateQ <= stateD;
      baudQ  <= baudD;
      bitQ   <= bitD;
      shiftQ <= shiftD;
      txQ    <= txD;
      ovfQ   <= ovfD;
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// A line monitor decodes frames at mid-bit; scenario tasks compare against hand-derived values.
module tb_mmio_uart_tx;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic tx;
  logic busy;

  mmio_uart_tx_if bus ();

  mmio_uart_tx #(
    .BASE_ADDR   (32'h0000_8000),
    .CLKS_PER_BIT(4),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus),
    .tx   (tx),
    .busy (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int passCnt  = 0;
  int totalCnt = 0;
  int ovfBase  = 0;

  // Frame monitor: pos 0 is the first low sample; bit n is sampled at pos 1+4n.
  bit         monActive = 1'b0;
  int         monPos    = 0;
  int         monStart  = 0;
  logic [9:0] monBits   = '0;
  logic [9:0] frQ[$];
  int         stQ[$];

  always @(negedge clk) begin
    if (!reset) begin
      monActive = 1'b0;
    end else if (!monActive) begin
      if (tx === 1'b0) begin
        monActive = 1'b1;
        monPos    = 0;
        monStart  = cyc;
      end
    end else begin
      monPos = monPos + 1;
      if ((monPos - 1) % 4 == 0) begin
        monBits[(monPos - 1) / 4] = tx;
      end
      if (monPos == 37) begin
        frQ.push_back(monBits);
        stQ.push_back(monStart);
        monActive = 1'b0;
      end
    end
  end

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1);
  end

  task automatic idleBus();
    bus.memAddress     = 32'h0;
    bus.memWriteData   = 32'h0;
    bus.memWriteEnable = 1'b0;
  endtask

  // Stores n words on consecutive edges; kFirst is the edge number of the first store.
  task automatic storeWords(input logic [31:0] addr, input logic [31:0] vals[6], input int n,
                            output int kFirst);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.memAddress     = addr;
      bus.memWriteData   = vals[i];
      bus.memWriteEnable = 1'b1;
    end
    @(negedge clk);
    idleBus();
    kFirst = cyc - n + 1;
    #1;
  endtask

  task automatic waitCyc(input int target);
    while (cyc < target) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic waitFrames(input int target, input int maxCycles);
    for (int i = 0; i < maxCycles && frQ.size() < target; i++) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    idleBus();
    reset = 1'b0;
    #20;
    reset = 1'b1;
    @(negedge clk);
    #1;
    totalCnt++;
    if (tx !== 1'b1) $display("FAIL reset_tx: got %b want 1", tx); else passCnt++;
    totalCnt++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passCnt++;
    bus.memAddress = 32'h0000_8004;
    #1;
    totalCnt++;
    if (bus.rdData !== 32'h0000_0004) $display("FAIL reset_status: got %h want 00000004",
                                                bus.rdData); else passCnt++;
    totalCnt++;
    if (bus.hit !== 1'b1) $display("FAIL hit_status: got %b want 1", bus.hit); else passCnt++;
    bus.memAddress = 32'h0000_8000;
    #1;
    totalCnt++;
    if (bus.hit !== 1'b1) $display("FAIL hit_data: got %b want 1", bus.hit); else passCnt++;
    totalCnt++;
    if (bus.rdData !== 32'h0) $display("FAIL rd_data_reg: got %h want 0", bus.rdData);
    else passCnt++;
    bus.memAddress = 32'h0001_8004;
    #1;
    totalCnt++;
    if (bus.hit !== 1'b0) $display("FAIL hit_miss: got %b want 0", bus.hit); else passCnt++;
    totalCnt++;
    if (bus.rdData !== 32'h0) $display("FAIL rd_miss: got %h want 0", bus.rdData);
    else passCnt++;
    idleBus();
  endtask

  task automatic test_decode();
    logic [31:0] v[6];
    int k;
    int base;
    base = frQ.size();
    v[0] = 32'h0000_00FF;
    storeWords(32'h0000_8008, v, 1, k);
    storeWords(32'h8000_8000, v, 1, k);
    waitCyc(cyc + 10);
    totalCnt++;
    if (busy !== 1'b0) $display("FAIL miss_busy: got %b want 0", busy); else passCnt++;
    totalCnt++;
    if (frQ.size() !== base) $display("FAIL miss_frames: got %0d want %0d", frQ.size(), base);
    else passCnt++;
  endtask

  task automatic test_single_byte();
    logic [31:0] v[6];
    logic [9:0]  got;
    int k;
    int base;
    int st;
    base = frQ.size();
    v[0] = 32'h1234_5655;
    storeWords(32'h0000_8000, v, 1, k);
    totalCnt++;
    if (busy !== 1'b1) $display("FAIL single_busy_early: got %b want 1", busy); else passCnt++;
    waitFrames(base + 1, 80);
    got = (frQ.size() > base) ? frQ[base] : 10'bx;
    st  = (stQ.size() > base) ? stQ[base] : -1;
    totalCnt++;
    if (got !== 10'b1_0101_0101_0) $display("FAIL single_bits: got %b want 1010101010", got);
    else passCnt++;
    totalCnt++;
    if (st !== k + 1) $display("FAIL single_latency: got start %0d want %0d", st, k + 1);
    else passCnt++;
    waitCyc(k + 40);
    totalCnt++;
    if (busy !== 1'b1) $display("FAIL single_busy_stop: got %b want 1", busy); else passCnt++;
    waitCyc(k + 41);
    totalCnt++;
    if (busy !== 1'b0) $display("FAIL single_busy_end: got %b want 0", busy); else passCnt++;
    totalCnt++;
    if (tx !== 1'b1) $display("FAIL single_tx_idle: got %b want 1", tx); else passCnt++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] v[6];
    logic [9:0]  got0, got1;
    int k;
    int base;
    int st0, st1;
    base = frQ.size();
    v[0] = 32'h0000_00A5;
    v[1] = 32'h0000_003C;
    storeWords(32'h0000_8000, v, 2, k);
    waitFrames(base + 2, 120);
    got0 = (frQ.size() > base) ? frQ[base] : 10'bx;
    got1 = (frQ.size() > base + 1) ? frQ[base + 1] : 10'bx;
    st0  = (stQ.size() > base) ? stQ[base] : -1;
    st1  = (stQ.size() > base + 1) ? stQ[base + 1] : -1000;
    totalCnt++;
    if (got0 !== {1'b1, 8'hA5, 1'b0}) $display("FAIL b2b_first: got %b want %b", got0,
                                               {1'b1, 8'hA5, 1'b0}); else passCnt++;
    totalCnt++;
    if (got1 !== {1'b1, 8'h3C, 1'b0}) $display("FAIL b2b_second: got %b want %b", got1,
                                               {1'b1, 8'h3C, 1'b0}); else passCnt++;
    totalCnt++;
    if (st1 - st0 !== 40) $display("FAIL b2b_gap: got spacing %0d want 40", st1 - st0);
    else passCnt++;
    waitCyc(k + 80);
    totalCnt++;
    if (busy !== 1'b1) $display("FAIL b2b_busy_last: got %b want 1", busy); else passCnt++;
    waitCyc(k + 81);
    totalCnt++;
    if (busy !== 1'b0) $display("FAIL b2b_busy_end: got %b want 0", busy); else passCnt++;
  endtask

  task automatic test_overflow();
    logic [31:0] v[6];
    int k;
    ovfBase = frQ.size();
    for (int i = 0; i < 6; i++) v[i] = 32'(i + 1);
    storeWords(32'h0000_8000, v, 6, k);
    bus.memAddress = 32'h0000_8004;
    #1;
    // busy, full, overflow set; four entries queued.
    totalCnt++;
    if (bus.rdData !== 32'h0000_004B) $display("FAIL ovf_status: got %h want 0000004b",
                                                bus.rdData); else passCnt++;
  endtask

  task automatic test_overflow_clear();
    bus.memAddress     = 32'h0000_8004;
    bus.memWriteData   = 32'h0000_0008;
    bus.memWriteEnable = 1'b1;
    @(negedge clk);
    bus.memWriteEnable = 1'b0;
    bus.memWriteData   = 32'h0;
    #1;
    totalCnt++;
    if (bus.rdData !== 32'h0000_0043) $display("FAIL ovf_clear: got %h want 00000043",
                                                bus.rdData); else passCnt++;
    idleBus();
  endtask

  task automatic test_overflow_frames();
    logic [9:0] got;
    waitFrames(ovfBase + 5, 5 * 40 + 40);
    for (int i = 0; i < 5; i++) begin
      got = (frQ.size() > ovfBase + i) ? frQ[ovfBase + i] : 10'bx;
      totalCnt++;
      if (got !== {1'b1, 8'(i + 1), 1'b0}) $display("FAIL ovf_frame%0d: got %b want %b", i,
                                                    got, {1'b1, 8'(i + 1), 1'b0});
      else passCnt++;
    end
    waitCyc(cyc + 60);
    totalCnt++;
    if (frQ.size() !== ovfBase + 5) $display("FAIL ovf_frame_count: got %0d want %0d",
                                             frQ.size() - ovfBase, 5); else passCnt++;
    bus.memAddress = 32'h0000_8004;
    #1;
    totalCnt++;
    if (bus.rdData !== 32'h0000_0004) $display("FAIL ovf_drain_status: got %h want 00000004",
                                                bus.rdData); else passCnt++;
    idleBus();
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] v[6];
    int k;
    int base;
    base = frQ.size();
    v[0] = 32'h0000_0000;
    v[1] = 32'h0000_0088;
    storeWords(32'h0000_8000, v, 2, k);
    waitCyc(k + 16);
    @(posedge clk);
    #1;
    totalCnt++;
    if (tx !== 1'b0) $display("FAIL midframe_tx_before: got %b want 0", tx); else passCnt++;
    #2;
    reset = 1'b0;
    #1;
    totalCnt++;
    if (tx !== 1'b1) $display("FAIL midframe_tx_async: got %b want 1", tx); else passCnt++;
    totalCnt++;
    if (busy !== 1'b0) $display("FAIL midframe_busy: got %b want 0", busy); else passCnt++;
    #16;
    @(negedge clk);
    reset = 1'b1;
    bus.memAddress = 32'h0000_8004;
    #1;
    totalCnt++;
    if (bus.rdData !== 32'h0000_0004) $display("FAIL midframe_status: got %h want 00000004",
                                                bus.rdData); else passCnt++;
    idleBus();
    waitCyc(cyc + 80);
    totalCnt++;
    if (frQ.size() !== base) $display("FAIL midframe_no_frames: got %0d want %0d",
                                      frQ.size(), base); else passCnt++;
    totalCnt++;
    if (busy !== 1'b0) $display("FAIL midframe_busy_after: got %b want 0", busy); else passCnt++;
  endtask

  initial begin
    idleBus();
    test_reset();
    test_decode();
    test_single_byte();
    test_back_to_back();
    test_overflow();
    test_overflow_clear();
    test_overflow_frames();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
